// File: rtl/quiz_round_controller.sv
// quiz_round_controller: sequences a two-player quiz game (question index, buzzer arbitration, judging, scores).
// Optional feature macro QRC_BUZZ_TIMEOUT_EN: skip a question after BUZZ_TIMEOUT cycles with no buzz.
module quiz_round_controller #(
  parameter int NUM_Q        = 11,
  parameter int WIN_SCORE    = 5,
  parameter int ANS_TIMEOUT  = 1000,
  parameter int BUZZ_TIMEOUT = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       btn_p1,
  input  logic       btn_p2,
  input  logic       ans_valid,
  input  logic [3:0] ans_val,
  input  logic [3:0] q_ans,
  output logic [3:0] q_state,
  output logic [1:0] owner,
  output logic [2:0] score_p1,
  output logic [2:0] score_p2,
  output logic       tick_p1,
  output logic       tick_p2,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHOW,
    S_ANSWER,
    S_JUDGE,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int TMR_MAX = (ANS_TIMEOUT > BUZZ_TIMEOUT) ? ANS_TIMEOUT : BUZZ_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] ANS_LAST = TMR_W'(ANS_TIMEOUT - 1);
`ifdef QRC_BUZZ_TIMEOUT_EN
  localparam logic [TMR_W-1:0] BUZZ_LAST = TMR_W'(BUZZ_TIMEOUT - 1);
`endif
  localparam logic [2:0] WIN_S  = 3'(WIN_SCORE);
  localparam logic [3:0] LAST_Q = 4'(NUM_Q - 1);

  function automatic logic [2:0] sat_inc(input logic [2:0] s);
    return (s >= WIN_S) ? WIN_S : s + 3'd1;
  endfunction

  function automatic logic [1:0] pick_winner(input logic [2:0] a, input logic [2:0] b);
    if (a > b) return 2'b01;
    if (b > a) return 2'b10;
    return 2'b11;
  endfunction

  state_t           state, state_nxt;
  logic             btn_p1_prev, btn_p2_prev;
  logic             buzz_p1, buzz_p2;
  logic             want_p1, want_p2;
  logic             lock_p1, lock_p2, lock_p1_nxt, lock_p2_nxt;
  logic             rr, rr_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [3:0]       ans_r, ans_nxt;
  logic             tmo_r, tmo_nxt;
  logic             correct;
  logic [1:0]       owner_nxt, winner_nxt;
  logic [3:0]       q_nxt;
  logic [2:0]       s1_nxt, s2_nxt, s1_inc, s2_inc;

  // Registered rising-edge pulses; a held button produces a single pulse only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_p1_prev <= 1'b0;
      btn_p2_prev <= 1'b0;
      buzz_p1     <= 1'b0;
      buzz_p2     <= 1'b0;
    end else begin
      btn_p1_prev <= btn_p1;
      btn_p2_prev <= btn_p2;
      buzz_p1     <= btn_p1 & ~btn_p1_prev;
      buzz_p2     <= btn_p2 & ~btn_p2_prev;
    end
  end

  assign want_p1   = buzz_p1 & ~lock_p1;
  assign want_p2   = buzz_p2 & ~lock_p2;
  assign correct   = ~tmo_r && (ans_r == q_ans);
  assign s1_inc    = sat_inc(score_p1);
  assign s2_inc    = sat_inc(score_p2);
  assign game_over = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    q_nxt       = q_state;
    s1_nxt      = score_p1;
    s2_nxt      = score_p2;
    lock_p1_nxt = lock_p1;
    lock_p2_nxt = lock_p2;
    rr_nxt      = rr;
    tmr_nxt     = '0;
    ans_nxt     = ans_r;
    tmo_nxt     = tmo_r;
    winner_nxt  = winner;
    tick_p1     = 1'b0;
    tick_p2     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt   = S_SHOW;
          owner_nxt   = 2'b00;
          q_nxt       = '0;
          s1_nxt      = '0;
          s2_nxt      = '0;
          lock_p1_nxt = 1'b0;
          lock_p2_nxt = 1'b0;
          winner_nxt  = 2'b00;
        end
      end
      S_SHOW: begin
        owner_nxt = 2'b00;
        if (lock_p1 && lock_p2) begin
          state_nxt = S_NEXT;
        end else if (want_p1 && want_p2) begin
          // Simultaneous buzz: round-robin pointer decides, then hands priority over.
          owner_nxt = rr ? 2'b10 : 2'b01;
          rr_nxt    = ~rr;
          state_nxt = S_ANSWER;
        end else if (want_p1) begin
          owner_nxt = 2'b01;
          state_nxt = S_ANSWER;
        end else if (want_p2) begin
          owner_nxt = 2'b10;
          state_nxt = S_ANSWER;
        end
`ifdef QRC_BUZZ_TIMEOUT_EN
        else if (tmr == BUZZ_LAST) begin
          state_nxt = S_NEXT;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
`endif
      end
      S_ANSWER: begin
        if (ans_valid) begin
          ans_nxt   = ans_val;
          tmo_nxt   = 1'b0;
          state_nxt = S_JUDGE;
        end else if (tmr == ANS_LAST) begin
          tmo_nxt   = 1'b1;
          state_nxt = S_JUDGE;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      S_JUDGE: begin
        owner_nxt = 2'b00;
        state_nxt = S_SHOW;
        if (correct) begin
          state_nxt = S_NEXT;
          if (owner == 2'b01) begin
            tick_p1 = 1'b1;
            s1_nxt  = s1_inc;
            if (s1_inc == WIN_S) begin
              state_nxt  = S_DONE;
              winner_nxt = 2'b01;
            end
          end else if (owner == 2'b10) begin
            tick_p2 = 1'b1;
            s2_nxt  = s2_inc;
            if (s2_inc == WIN_S) begin
              state_nxt  = S_DONE;
              winner_nxt = 2'b10;
            end
          end
        end else begin
          // Wrong or timed out: owner sits out, the other player may steal.
          if (owner == 2'b01) lock_p1_nxt = 1'b1;
          if (owner == 2'b10) lock_p2_nxt = 1'b1;
        end
      end
      S_NEXT: begin
        lock_p1_nxt = 1'b0;
        lock_p2_nxt = 1'b0;
        if (q_state >= LAST_Q) begin
          state_nxt  = S_DONE;
          winner_nxt = pick_winner(score_p1, score_p2);
        end else begin
          q_nxt     = q_state + 4'd1;
          state_nxt = S_SHOW;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner    <= 2'b00;
      q_state  <= '0;
      score_p1 <= '0;
      score_p2 <= '0;
      winner   <= 2'b00;
      lock_p1  <= 1'b0;
      lock_p2  <= 1'b0;
      rr       <= 1'b0;
      tmr      <= '0;
      ans_r    <= '0;
      tmo_r    <= 1'b0;
    end else begin
      owner    <= owner_nxt;
      q_state  <= q_nxt;
      score_p1 <= s1_nxt;
      score_p2 <= s2_nxt;
      winner   <= winner_nxt;
      lock_p1  <= lock_p1_nxt;
      lock_p2  <= lock_p2_nxt;
      rr       <= rr_nxt;
      tmr      <= tmr_nxt;
      ans_r    <= ans_nxt;
      tmo_r    <= tmo_nxt;
    end
  end

endmodule
